// File: rtl/ddr3_reset_n_seq_pkg.sv
// rtl/ddr3_reset_n_seq_pkg.sv - shared state encoding and timing helpers for the DDR3 RESET_N sequencer
package ddr3_reset_n_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_CKE = 3'd4,
        ST_DONE     = 3'd5,
        ST_CKE_OFF  = 3'd6
    } state_e;

    function automatic int calc_n_rst(input int clk_mhz, input int t_reset_us);
        return clk_mhz * t_reset_us;
    endfunction

    function automatic int calc_n_cke(input int clk_mhz, input int t_cke_us);
        return clk_mhz * t_cke_us;
    endfunction

    function automatic int calc_cnt_width(input int n_rst, input int n_cke, input int n_settle);
        int m;
        m = n_rst;
        if (n_cke > m) m = n_cke;
        if (n_settle > m) m = n_settle;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ddr3_reset_n_seq_timer.sv
// rtl/ddr3_reset_n_seq_timer.sv - loadable down-counter with zero flag, shared by SETTLE/HOLD/WAIT_CKE
module ddr3_reset_n_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Holds at zero rather than wrapping; the sequencer reloads on every state entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr3_reset_n_seq.sv
// rtl/ddr3_reset_n_seq.sv - DDR3 RESET_N / CKE power-up sequencer driving the RESET_N output IOD
module ddr3_reset_n_seq
    import ddr3_reset_n_seq_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 200,
    parameter int T_RESET_US   = 200,
    parameter int T_CKE_US     = 500,
    parameter int DLY_SETTLE   = 8
) (
    input  logic       FAB_CLK,
    input  logic       TX_SYNC_RST,
    input  logic       INIT_START,
    input  logic       SW_RESET_REQ,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       ODT_EN_0,
    output logic       CKE_EN,
    output logic       INIT_DONE,
    output logic       DLY_ERR
);

    localparam int N_RST = calc_n_rst(CLK_FREQ_MHZ, T_RESET_US);
    localparam int N_CKE = calc_n_cke(CLK_FREQ_MHZ, T_CKE_US);
    localparam int CW    = calc_cnt_width(N_RST, N_CKE, DLY_SETTLE);

    localparam logic [CW-1:0] LD_SETTLE = CW'(DLY_SETTLE - 1);
    localparam logic [CW-1:0] LD_RST    = CW'(N_RST - 1);
    localparam logic [CW-1:0] LD_CKE    = CW'(N_CKE - 1);

    state_e          state_q, state_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_zero;
    logic [3:0]      tx_q, tx_d;
    logic            load_q, load_d;
    logic            cke_q, cke_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    ddr3_reset_n_seq_timer #(.W(CW)) u_timer (
        .clk_i      (FAB_CLK),
        .rst_i      (TX_SYNC_RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state_q <= ST_IDLE;
            tx_q    <= 4'b0000;
            load_q  <= 1'b0;
            cke_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            load_q  <= load_d;
            cke_q   <= cke_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // A re-reset request in HOLD/WAIT_CKE takes priority over timer expiry.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (INIT_START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = LD_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end
            end
            ST_HOLD, ST_WAIT_CKE: begin
                if (SW_RESET_REQ) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end else if (tmr_zero) begin
                    state_d = (state_q == ST_HOLD) ? ST_WAIT_CKE : ST_DONE;
                    if (state_q == ST_HOLD) begin
                        tmr_load = 1'b1;
                        tmr_val  = LD_CKE;
                    end
                end
            end
            ST_DONE: begin
                if (SW_RESET_REQ) state_d = ST_CKE_OFF;
            end
            ST_CKE_OFF: begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = LD_RST;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so the registered pins line up with state_q.
    always_comb begin
        tx_d   = 4'b0000;
        load_d = 1'b0;
        cke_d  = 1'b0;
        done_d = 1'b0;
        err_d  = err_q | (DELAY_LINE_OUT_OF_RANGE_0 & (state_q != ST_IDLE));
        case (state_d)
            ST_LOAD:     load_d = 1'b1;
            ST_WAIT_CKE: tx_d   = 4'b1111;
            ST_CKE_OFF:  tx_d   = 4'b1111;
            ST_DONE: begin
                tx_d   = 4'b1111;
                cke_d  = 1'b1;
                done_d = 1'b1;
            end
            default: tx_d = 4'b0000;
        endcase
    end

    assign TX_DATA_0              = tx_q;
    assign OE_DATA_0              = 4'b1111;
    assign DELAY_LINE_LOAD_0      = load_q;
    assign DELAY_LINE_MOVE_0      = 1'b0;
    assign DELAY_LINE_DIRECTION_0 = 1'b0;
    assign ODT_EN_0               = 1'b0;
    assign CKE_EN                 = cke_q;
    assign INIT_DONE              = done_q;
    assign DLY_ERR                = err_q;

endmodule
